// File: rtl/swi_pkg.sv
// swi_pkg: shared switch-conditioner constants.
package swi_pkg;
  localparam int NBITS_SWI = 8;
  localparam int DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one switch line -- 2-flop sync, optional debounce counter, clean level and edge pulses.
// Define SWI_DEBOUNCE_EN to enable the stability counter; otherwise the sync value is registered once.
module debounce_bit
  import swi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_2,
  input  logic reset,
  input  logic swi_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  logic s1_q, s2_q, clean_q, clean_d, prev_q;
`ifdef SWI_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff;
  always_comb begin
    diff = s2_q != clean_q;
    cnt_d = (!diff || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    clean_d = (diff && cnt_q == LAST) ? s2_q : clean_q;
  end
  always_ff @(posedge clk_2 or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb clean_d = s2_q;
`endif
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      clean_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q <= swi_i;
      s2_q <= s1_q;
      clean_q <= clean_d;
      prev_q <= clean_q;
    end
  end
  assign clean_o = clean_q;
  assign rise_o = clean_q & ~prev_q;
  assign fall_o = ~clean_q & prev_q;
endmodule

// File: rtl/swi_conditioner.sv
// swi_conditioner: NBITS independent switch conditioners (sync, debounce, edge detect).
// Debouncing is built only when SWI_DEBOUNCE_EN is defined.
module swi_conditioner
  import swi_pkg::*;
#(
  parameter int NBITS = NBITS_SWI,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] sw_clean,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall
);
  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk_2  (clk_2),
      .reset  (reset),
      .swi_i  (SWI[i]),
      .clean_o(sw_clean[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end
endmodule

// File: tb/tb_swi_conditioner.sv
// tb_swi_conditioner: scoreboard bench with a per-edge reference model of the switch conditioner.
module tb_swi_conditioner;
  import swi_pkg::*;
  localparam int N = NBITS_SWI;
  localparam int D = DEBOUNCE_DEFAULT;
`ifdef SWI_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 3;
`endif
  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] SWI = '0;
  logic [N-1:0] sw_clean, sw_rise, sw_fall;
  int checks = 0;
  int passes = 0;
  typedef struct packed {
    logic [N-1:0] c;
    logic [N-1:0] r;
    logic [N-1:0] f;
  } exp_t;
  exp_t q[$];

  always #5 clk_2 = ~clk_2;

  swi_conditioner dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .SWI     (SWI),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: a change is accepted once the synced level has disagreed with the
  // clean level for D consecutive edges; the synced level is the input two edges ago.
  initial begin : model
    logic [N-1:0] p1, p2, mc, mp;
    int run[N];
    p1 = '0; p2 = '0; mc = '0; mp = '0;
    foreach (run[i]) run[i] = 0;
    forever begin
      @(posedge clk_2);
      if (!reset) begin
        p1 = '0; p2 = '0; mc = '0; mp = '0;
        foreach (run[i]) run[i] = 0;
      end else begin
        mp = mc;
`ifdef SWI_DEBOUNCE_EN
        for (int i = 0; i < N; i++) begin
          if (p2[i] != mc[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == D) begin
              mc[i] = p2[i];
              run[i] = 0;
            end
          end else run[i] = 0;
        end
`else
        mc = p2;
`endif
        p2 = p1;
        p1 = SWI;
      end
      q.push_back('{c: mc, r: mc & ~mp, f: ~mc & mp});
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_2);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("outputs", {8'h00, sw_clean, sw_rise, sw_fall}, {8'h00, e});
        check("rise_fall_excl", {24'h0, sw_rise & sw_fall}, 32'h0);
      end
    end
  end

  task automatic set_swi(input logic [N-1:0] v);
    @(negedge clk_2);
    #2 SWI = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk_2);
  endtask

  task automatic time_to(input logic [N-1:0] v, input string nm);
    int k;
    k = 0;
    for (int e = 1; e <= 4 * LAT + 10; e++) begin
      @(posedge clk_2);
      #1;
      if (sw_clean == v) begin
        k = e;
        break;
      end
    end
    check(nm, k, LAT);
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk_2);
    #2 reset = 1'b0;
    #1 check("reset_immediate", {8'h00, sw_clean, sw_rise, sw_fall}, 32'h0);
    hold(n);
    @(negedge clk_2);
    #2 reset = 1'b1;
  endtask

  initial begin : stim
    hold(3);
    #1 check("reset_state", {8'h00, sw_clean, sw_rise, sw_fall}, 32'h0);
    @(negedge clk_2);
    #2 reset = 1'b1;
    hold(20);
    #1 check("s1_clean", sw_clean, 32'h0);
    set_swi(8'h05);
    time_to(8'h05, "s2_latency");
    check("s2_rise", sw_rise, 32'h05);
    @(posedge clk_2);
    #1 check("s2_rise_gone", sw_rise, 32'h0);
    set_swi(8'h07);
    hold(3);
    set_swi(8'h05);
    hold(15);
    set_swi(8'hFF);
    hold(15);
    set_swi(8'h0F);
    time_to(8'h0F, "s4_latency");
    check("s4_fall", sw_fall, 32'hF0);
    hold(10);
    set_swi(8'hAA);
    hold(5);
    reset_pulse(2);
    time_to(8'hAA, "s5_latency");
    hold(10);
    repeat (60) begin
      if ($urandom_range(0, 15) == 0) reset_pulse($urandom_range(1, 3));
      set_swi(N'($urandom));
      hold($urandom_range(1, 8));
    end
    hold(12);
    @(negedge clk_2);
    #3 $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/swi_conditioner.md
SWI_CONDITIONER -- requirements
Module: swi_conditioner

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, giving the number of switch lines conditioned.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the stable-cycle count for a switch change to be accepted; legal range 1..255.
REQ-003 The block SHALL have port clk_2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port SWI, input, NBITS: raw, asynchronous switch levels.
REQ-006 The block SHALL have port sw_clean, output, NBITS: synchronized, debounced switch levels, which feed the downstream counter's reset/count/load/data controls.
REQ-007 The block SHALL have port sw_rise, output, NBITS: one-cycle pulse per bit on each 0->1 transition of sw_clean.
REQ-008 The block SHALL have port sw_fall, output, NBITS: one-cycle pulse per bit on each 1->0 transition of sw_clean.

Function
REQ-009 Each SWI bit SHALL pass through a two-flop synchronizer; the second-flop output is the bit's sync value.
REQ-010 Each bit SHALL have an independent stability counter of width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-011 On each edge where sync value equals sw_clean, the bit's counter SHALL clear to 0.
REQ-012 On each edge where sync value differs from sw_clean and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 On the edge where sync value differs from sw_clean and counter == DEBOUNCE_CYCLES-1, sw_clean SHALL take the sync value and the counter SHALL clear to 0.
REQ-014 Latency: a SWI change held stable SHALL appear on sw_clean exactly 2+DEBOUNCE_CYCLES rising edges after it is first sampled (6 edges at default).
REQ-015 A SWI pulse whose sync value differs from sw_clean for fewer than DEBOUNCE_CYCLES consecutive edges SHALL leave sw_clean unchanged and clear the counter.
REQ-016 sw_rise[i] SHALL be high for exactly the one cycle in which sw_clean[i] is 1 and its registered previous value is 0; sw_fall[i] is the mirror case.
REQ-017 sw_rise[i] and sw_fall[i] SHALL never be high in the same cycle.
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits SHALL produce simultaneous pulses with no interaction.
REQ-019 Counters SHALL never wrap; they saturate at DEBOUNCE_CYCLES-1 only momentarily before clearing per REQ-013.

Reset
REQ-020 While reset is 0, all synchronizer flops, counters, sw_clean, and the previous-value register SHALL be 0; sw_rise and sw_fall SHALL be 0.
REQ-021 Reset assertion mid-count SHALL discard the partial count immediately and asynchronously.
REQ-022 After reset release with a switch already at 1, the block SHALL produce a normal sw_rise pulse after the REQ-014 latency; no start-up suppression.

Configuration
REQ-023 With macro SWI_DEBOUNCE_EN defined, the block SHALL debounce per REQ-010..REQ-015.
REQ-024 Without SWI_DEBOUNCE_EN, the block SHALL omit the counters; sw_clean SHALL be the sync value registered once (latency 3 edges), and edge outputs SHALL be unchanged in meaning.

Structure
REQ-025 Package swi_pkg SHALL hold NBITS_SWI (8) and DEBOUNCE_DEFAULT (4) constants, shared with top.
REQ-026 Sub-module debounce_bit SHALL implement one synchronizer, counter, clean bit, and edge pair; swi_conditioner SHALL instantiate NBITS copies through a generate loop.

Verification
REQ-027 Scenario 1: reset=0 then 1, SWI=8'h00 held for 20 cycles -> sw_clean=8'h00, no pulses.
REQ-028 Scenario 2: SWI 8'h00->8'h05 held -> sw_clean=8'h05 on the 6th edge, and sw_rise=8'h05 for exactly 1 cycle.
REQ-029 Scenario 3: SWI[1] high for 3 cycles then low -> sw_clean[1] stays 0, with no sw_rise[1].
REQ-030 Scenario 4: sw_clean=8'hFF, then SWI=8'h0F -> sw_fall=8'hF0 for 1 cycle 6 edges later, and sw_clean=8'h0F.
REQ-031 Scenario 5: reset pulsed low during the 4th stable cycle of a change -> outputs 0 immediately, and the change reappears 6 edges after release.
REQ-032 Scenario 6: built without SWI_DEBOUNCE_EN, SWI 0->8'h80 -> sw_clean[7]=1 and sw_rise[7]=1 on the 3rd edge.
